// File: rtl/ls_mem_arbiter.sv
// ==========================================================================
// ls_mem_arbiter: shares one byte-wide RAM port between IF and LS, byte-serial
// Rev 1.0
// ==========================================================================
`default_nettype none

module ls_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter bit LS_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic [3:0]        ls_op,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_prio_ls;
  logic        r_own_ls;
  logic [2:0]  r_op;
  logic [2:0]  r_n;
  logic [2:0]  r_k;
  logic [31:0] r_buf;
  logic [31:0] r_wdata;

  logic              w_grant_ls;
  logic [2:0]        w_op;
  logic [2:0]        w_n;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_rd_lane;
  logic [1:0]        w_wr_lane;
  logic [31:0]       w_full;
  logic [31:0]       w_ext;
  logic              unused_addr_bits;

  // Both requesting: the priority owner wins; a lone requester always wins.
  assign w_grant_ls = ls_req && (!if_req || r_prio_ls);
  assign w_op       = w_grant_ls ? ls_op[2:0] : 3'b010;
  assign w_addr     = w_grant_ls ? ls_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
  assign unused_addr_bits = ^{if_addr, ls_addr};

  always_comb begin
    case (w_op[1:0])
      2'd0:    w_n = 3'd1;
      2'd1:    w_n = 3'd2;
      default: w_n = 3'd4;
    endcase
  end

  // Read data lags its address by one cycle, so byte k lands when r_k == k+1.
  assign w_rd_lane = r_k[1:0] - 2'd1;
  assign w_wr_lane = r_k[1:0] + 2'd1;

  always_comb begin
    w_full = r_buf;
    w_full[{w_rd_lane, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    case (r_op[1:0])
      2'd0:    w_ext = {{24{~r_op[2] & w_full[7]}}, w_full[7:0]};
      2'd1:    w_ext = {{16{~r_op[2] & w_full[15]}}, w_full[15:0]};
      default: w_ext = w_full;
    endcase
  end

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_prio_ls <= LS_FIRST;
      r_own_ls  <= 1'b0;
      r_op      <= 3'd0;
      r_n       <= 3'd0;
      r_k       <= 3'd0;
      r_buf     <= 32'd0;
      r_wdata   <= 32'd0;
      if_done   <= 1'b0;
      if_data   <= 32'd0;
      ls_done   <= 1'b0;
      ls_rdata  <= 32'd0;
      mem_a     <= '0;
      mem_wr    <= 1'b0;
      mem_dout  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (if_req || ls_req) begin
            r_own_ls <= w_grant_ls;
            if (if_req && ls_req) r_prio_ls <= ~r_prio_ls;
            r_op    <= w_op;
            r_n     <= w_n;
            r_k     <= 3'd0;
            r_wdata <= ls_wdata;
            mem_a   <= w_addr;
            if (w_grant_ls && ls_op[3]) begin
              mem_wr   <= 1'b1;
              mem_dout <= ls_wdata[7:0];
              r_state  <= WR;
            end else begin
              r_state <= RD;
            end
          end
        end
        RD: begin
          if (r_k != 3'd0) r_buf[{w_rd_lane, 3'b000} +: 8] <= mem_din;
          if (r_k == r_n) begin
            r_state <= DONE;
            if (r_own_ls) begin
              ls_done  <= 1'b1;
              ls_rdata <= w_ext;
            end else begin
              if_done <= 1'b1;
              if_data <= w_full;
            end
          end else begin
            if (r_k + 3'd1 < r_n) mem_a <= mem_a + ADDR_W'(1);
            r_k <= r_k + 3'd1;
          end
        end
        WR: begin
          if (r_k + 3'd1 < r_n) begin
            mem_a    <= mem_a + ADDR_W'(1);
            mem_dout <= r_wdata[{w_wr_lane, 3'b000} +: 8];
            r_k      <= r_k + 3'd1;
          end else begin
            mem_wr   <= 1'b0;
            r_state  <= DONE;
            ls_done  <= 1'b1;
            ls_rdata <= 32'd0;
          end
        end
        DONE: begin
          if_done  <= 1'b0;
          ls_done  <= 1'b0;
          if_data  <= 32'd0;
          ls_rdata <= 32'd0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ls_mem_arbiter.sv
// ==========================================================================
// tb_ls_mem_arbiter: directed and randomized checks against a transaction model
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_ls_mem_arbiter;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, ls_req;
  logic [31:0]   if_addr, ls_addr, ls_wdata;
  logic [3:0]    ls_op;
  logic          if_done, ls_done, mem_wr, busy;
  logic [31:0]   if_data, ls_rdata;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_dout, mem_din;

  bit [7:0]    ram    [0:65535];
  bit [7:0]    shadow [0:65535];
  logic        tb_we;
  logic [15:0] tb_wa;
  logic [7:0]  tb_wd;

  int checks = 0;
  int failures = 0;
  bit m_prio_ls;
  int order[$];
  logic [31:0] g_if, g_ls;

  always #5 clk = ~clk;

  ls_mem_arbiter #(.ADDR_W(AW), .LS_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_op(ls_op), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .busy(busy)
  );

  // RAM: read data appears the cycle after its address
  always @(posedge clk) begin
    mem_din <= ram[mem_a];
    if (mem_wr) ram[mem_a] = mem_dout;
    if (tb_we) ram[tb_wa] = tb_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] op);
    return (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n,
                                             input bit ext, input bit uns);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++) v = v + (32'(shadow[16'(a + 32'(k))]) << (8 * k));
    if (ext && !uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    shadow[a] = d;
  endtask

  task automatic serve(input bit w_if, input bit w_ls, input logic [31:0] ia,
                       input logic [3:0] op, input logic [31:0] la, input logic [31:0] wd,
                       output logic [31:0] got_if, output logic [31:0] got_ls);
    int nl = nbytes(op);
    bit st = op[3];
    int lat_i = 6;
    int lat_l = st ? nl + 1 : nl + 2;
    int t0_i = 0, t0_l = 0, last, ji, jl;
    bit e_busy;
    logic [31:0] e_if = model_read(ia, 4, 1'b0, 1'b0);
    logic [31:0] e_ls = st ? 32'd0 : model_read(la, nl, 1'b1, op[2]);
    if (w_if && w_ls) begin
      if (m_prio_ls) t0_i = lat_l + 1; else t0_l = lat_i + 1;
      m_prio_ls = !m_prio_ls;
    end
    last = w_if ? t0_i + lat_i : 0;
    if (w_ls && t0_l + lat_l > last) last = t0_l + lat_l;
    last = last + 2;
    got_if = 32'd0; got_ls = 32'd0;
    @(negedge clk);
    if_req = w_if; ls_req = w_ls; if_addr = ia; ls_op = op; ls_addr = la; ls_wdata = wd;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      ji = c - t0_i - 1;
      jl = c - t0_l - 1;
      e_busy = (w_if && c > t0_i && c <= t0_i + lat_i) || (w_ls && c > t0_l && c <= t0_l + lat_l);
      check("busy", busy, e_busy);
      check("if_done", if_done, w_if && c == t0_i + lat_i);
      check("ls_done", ls_done, w_ls && c == t0_l + lat_l);
      check("mem_wr", mem_wr, w_ls && st && jl >= 0 && jl < nl);
      if (w_if && ji >= 0 && ji < 4) check("if_mem_a", mem_a, 16'(ia + 32'(ji)));
      if (w_ls && jl >= 0 && jl < nl) begin
        check("ls_mem_a", mem_a, 16'(la + 32'(jl)));
        if (st) check("mem_dout", mem_dout, (wd >> (8 * jl)) & 32'hFF);
      end
      if (if_done) begin
        got_if = if_data;
        if (w_if) check("if_data", if_data, e_if);
        if_req = 1'b0;
      end
      if (ls_done) begin
        got_ls = ls_rdata;
        if (w_ls) check("ls_rdata", ls_rdata, e_ls);
        ls_req = 1'b0;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    if (w_ls && st) begin
      for (int k = 0; k < nl; k++) shadow[16'(la + 32'(k))] = wd[8*k +: 8];
      for (int k = 0; k <= nl; k++)
        check("ram_after_store", ram[16'(la + 32'(k))], shadow[16'(la + 32'(k))]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] a16;
    logic [31:0] ia, la, wd;
    logic [3:0]  op;
    int mode;

    rst_n = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h200; ls_addr = 32'h220;
    ls_op = 4'h2; ls_wdata = 32'd0; m_prio_ls = 1'b1;

    // Preload memory while held in reset
    for (int i = 0; i < 64; i++) poke(16'(16'h200 + i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 16; i++) poke(16'(16'hFFF0 + i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 16; i++) poke(16'(i), 8'($urandom_range(0, 255)));
    poke(16'h100, 8'h11); poke(16'h101, 8'h22); poke(16'h102, 8'h33); poke(16'h103, 8'h44);
    poke(16'h020, 8'h80); poke(16'h043, 8'h5A);
    @(negedge clk); tb_we = 1'b0;

    check("rst_busy", busy, 1'b0);
    check("rst_mem_a", mem_a, 16'h0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_dout", mem_dout, 8'h0);
    check("rst_if_done", if_done, 1'b0);
    check("rst_ls_done", ls_done, 1'b0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);

    // Both requesters held from reset: grants alternate starting with LS
    rst_n = 1'b1;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      @(negedge clk);
      if (ls_done) order.push_back(1);
      if (if_done) order.push_back(0);
    end
    if_req = 1'b0; ls_req = 1'b0;
    check("arb_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      check("arb_order", (i < order.size()) ? order[i] : 99, (i % 2 == 0) ? 1 : 0);
    repeat (2) @(negedge clk);

    serve(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 32'h0, g_if, g_ls);
    check("if_word_0x100", g_if, 32'h4433_2211);

    serve(1'b0, 1'b1, 32'h0, 4'h0, 32'h20, 32'h0, g_if, g_ls);
    check("ls_byte_signed", g_ls, 32'hFFFF_FF80);
    serve(1'b0, 1'b1, 32'h0, 4'h4, 32'h20, 32'h0, g_if, g_ls);
    check("ls_byte_unsigned", g_ls, 32'h0000_0080);

    serve(1'b0, 1'b1, 32'h0, 4'h9, 32'h41, 32'hDEAD_BEEF, g_if, g_ls);
    check("store_0x41", ram[16'h41], 8'hEF);
    check("store_0x42", ram[16'h42], 8'hBE);
    check("store_0x43_untouched", ram[16'h43], 8'h5A);

    serve(1'b1, 1'b0, 32'hABCD_FFFE, 4'h0, 32'h0, 32'h0, g_if, g_ls);

    // Reset in the middle of a read: no done pulse, clean restart
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) @(negedge clk);
    check("mid_rd_mem_a", mem_a, 16'h102);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_mem_a", mem_a, 16'h0);
    check("async_if_done", if_done, 1'b0);
    check("async_if_data", if_data, 32'h0);
    check("async_mem_wr", mem_wr, 1'b0);
    if_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", if_done, 1'b0);
    end
    rst_n = 1'b1;
    m_prio_ls = 1'b1;
    serve(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 32'h0, g_if, g_ls);
    check("after_rst_if_word", g_if, 32'h4433_2211);

    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) a16 = 16'(16'h200 + $urandom_range(0, 28));
      else a16 = 16'(16'hFFFC + $urandom_range(0, 9));
      ia = ($urandom() & 32'hFFFF_0000) | {16'h0, a16};
      la = ($urandom() & 32'hFFFF_0000) | (32'h220 + 32'($urandom_range(0, 28)));
      op = 4'($urandom_range(0, 15));
      wd = $urandom();
      serve(mode != 1, mode != 0, ia, op, la, wd, g_if, g_ls);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
